// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//    Shares the single AXI bridge request port between the instruction cache
//    and the data cache. One transaction is in flight at a time. The owner
//    gets the bridge completion forwarded back to it in the same cycle.
//    The data side has priority. After MAX_D_STREAK consecutive D grants
//    made while I was waiting, the next grant goes to I.
//
// Ports
//    clk, rst                  clock, synchronous active-high reset
//    i_req_valid, i_req_addr   icache read request (held until i_res_valid)
//    i_res_valid, i_mrdata     icache completion pulse and read data
//    d_req_*                   dcache read/write request (held until d_res_valid)
//    d_res_valid, d_mrdata     dcache completion pulse and read data
//    m_req_*                   registered request to the bridge
//    m_res_valid, m_mrdata     bridge completion pulse and read data
//    grant_d, grant_i          registered ownership flags (debug/perf)
module cache_mem_arbiter #(
   parameter int ADDR_WIDTH   = 64,
   parameter int LINE_WIDTH   = 128,
   parameter int STRB_WIDTH   = 8,
   parameter int MAX_D_STREAK = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_req_valid,
   input  logic [ADDR_WIDTH-1:0] i_req_addr,
   output logic                  i_res_valid,
   output logic [LINE_WIDTH-1:0] i_mrdata,
   input  logic                  d_req_valid,
   input  logic                  d_req_wen,
   input  logic [ADDR_WIDTH-1:0] d_req_addr,
   input  logic [STRB_WIDTH-1:0] d_req_strb,
   input  logic [LINE_WIDTH-1:0] d_req_data,
   output logic                  d_res_valid,
   output logic [LINE_WIDTH-1:0] d_mrdata,
   output logic                  m_req_valid,
   output logic                  m_req_wen,
   output logic [ADDR_WIDTH-1:0] m_req_addr,
   output logic [STRB_WIDTH-1:0] m_req_strb,
   output logic [LINE_WIDTH-1:0] m_req_data,
   input  logic                  m_res_valid,
   input  logic [LINE_WIDTH-1:0] m_mrdata,
   output logic                  grant_d,
   output logic                  grant_i
);

   localparam int STREAK_W = $clog2(MAX_D_STREAK) + 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      D_BUSY = 2'd1,
      I_BUSY = 2'd2
   } state_t;

   state_t                state_r;
   state_t                state_next_s;
   logic [STREAK_W-1:0]   d_streak_r;
   logic [STREAK_W-1:0]   d_streak_next_s;
   logic                  pick_d_s;
   logic                  pick_i_s;

   // Read data goes to both caches; each qualifies it with its own res_valid.
   assign i_mrdata = m_mrdata;
   assign d_mrdata = m_mrdata;

   // Arbitration, streak bookkeeping, completion routing and next state.
   always_comb begin
      state_next_s    = state_r;
      d_streak_next_s = d_streak_r;
      pick_d_s        = 1'b0;
      pick_i_s        = 1'b0;
      i_res_valid     = 1'b0;
      d_res_valid     = 1'b0;
      case (state_r)
         IDLE: begin
            // D wins unless I is waiting and D has used up its streak.
            if (d_req_valid && (!i_req_valid || (d_streak_r < STREAK_W'(MAX_D_STREAK)))) begin
               pick_d_s     = 1'b1;
               state_next_s = D_BUSY;
               if (i_req_valid) begin
                  if (d_streak_r != {STREAK_W{1'b1}}) begin
                     d_streak_next_s = d_streak_r + STREAK_W'(1);
                  end else begin
                     d_streak_next_s = d_streak_r;
                  end
               end else begin
                  d_streak_next_s = {STREAK_W{1'b0}};
               end
            end else if (i_req_valid) begin
               pick_i_s        = 1'b1;
               state_next_s    = I_BUSY;
               d_streak_next_s = {STREAK_W{1'b0}};
            end else begin
               state_next_s = IDLE;
            end
         end
         D_BUSY: begin
            if (m_res_valid) begin
               d_res_valid  = 1'b1;
               state_next_s = IDLE;
            end else begin
               state_next_s = D_BUSY;
            end
         end
         I_BUSY: begin
            if (m_res_valid) begin
               i_res_valid  = 1'b1;
               state_next_s = IDLE;
            end else begin
               state_next_s = I_BUSY;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // State, streak counter, registered bridge request and grant flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         d_streak_r  <= {STREAK_W{1'b0}};
         m_req_valid <= 1'b0;
         m_req_wen   <= 1'b0;
         m_req_addr  <= {ADDR_WIDTH{1'b0}};
         m_req_strb  <= {STRB_WIDTH{1'b0}};
         m_req_data  <= {LINE_WIDTH{1'b0}};
         grant_d     <= 1'b0;
         grant_i     <= 1'b0;
      end else begin
         state_r    <= state_next_s;
         d_streak_r <= d_streak_next_s;
         grant_d    <= (state_next_s == D_BUSY);
         grant_i    <= (state_next_s == I_BUSY);
         if (pick_d_s) begin
            m_req_valid <= 1'b1;
            m_req_wen   <= d_req_wen;
            m_req_addr  <= d_req_addr;
            m_req_strb  <= d_req_strb;
            m_req_data  <= d_req_data;
         end else if (pick_i_s) begin
            // Instruction fetches are always plain reads.
            m_req_valid <= 1'b1;
            m_req_wen   <= 1'b0;
            m_req_addr  <= i_req_addr;
            m_req_strb  <= {STRB_WIDTH{1'b0}};
            m_req_data  <= {LINE_WIDTH{1'b0}};
         end else if (state_next_s == IDLE) begin
            m_req_valid <= 1'b0;
         end else begin
            m_req_valid <= m_req_valid;
         end
      end
   end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;

   logic         clk;
   logic         rst;
   logic         i_req_valid;
   logic [63:0]  i_req_addr;
   logic         i_res_valid;
   logic [127:0] i_mrdata;
   logic         d_req_valid;
   logic         d_req_wen;
   logic [63:0]  d_req_addr;
   logic [7:0]   d_req_strb;
   logic [127:0] d_req_data;
   logic         d_res_valid;
   logic [127:0] d_mrdata;
   logic         m_req_valid;
   logic         m_req_wen;
   logic [63:0]  m_req_addr;
   logic [7:0]   m_req_strb;
   logic [127:0] m_req_data;
   logic         m_res_valid;
   logic [127:0] m_mrdata;
   logic         grant_d;
   logic         grant_i;

   cache_mem_arbiter #(
      .ADDR_WIDTH(64), .LINE_WIDTH(128), .STRB_WIDTH(8), .MAX_D_STREAK(4)
   ) dut (
      .clk(clk), .rst(rst),
      .i_req_valid(i_req_valid), .i_req_addr(i_req_addr),
      .i_res_valid(i_res_valid), .i_mrdata(i_mrdata),
      .d_req_valid(d_req_valid), .d_req_wen(d_req_wen), .d_req_addr(d_req_addr),
      .d_req_strb(d_req_strb), .d_req_data(d_req_data),
      .d_res_valid(d_res_valid), .d_mrdata(d_mrdata),
      .m_req_valid(m_req_valid), .m_req_wen(m_req_wen), .m_req_addr(m_req_addr),
      .m_req_strb(m_req_strb), .m_req_data(m_req_data),
      .m_res_valid(m_res_valid), .m_mrdata(m_mrdata),
      .grant_d(grant_d), .grant_i(grant_i)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // ---------------- behavioural model ----------------
   // owner: 0 = nobody, 1 = data cache, 2 = instruction cache
   int           mdl_owner = 0;
   int           mdl_streak = 0;
   bit           mdl_fields_known = 1'b0;
   bit           ready = 1'b0;
   logic         mdl_wen;
   logic [63:0]  mdl_addr;
   logic [7:0]   mdl_strb;
   logic [127:0] mdl_data;

   always @(posedge clk) begin
      if (rst) begin
         mdl_owner = 0; mdl_streak = 0;
         mdl_wen = 1'b0; mdl_addr = 64'd0; mdl_strb = 8'd0; mdl_data = 128'd0;
         mdl_fields_known = 1'b1;
         ready = 1'b1;
      end else if (mdl_owner == 0) begin
         if (d_req_valid && (!i_req_valid || mdl_streak < 4)) begin
            mdl_owner = 1;
            mdl_wen = d_req_wen; mdl_addr = d_req_addr;
            mdl_strb = d_req_strb; mdl_data = d_req_data;
            mdl_streak = i_req_valid ? ((mdl_streak < 7) ? mdl_streak + 1 : 7) : 0;
            mdl_fields_known = 1'b1;
         end else if (i_req_valid) begin
            mdl_owner = 2;
            mdl_wen = 1'b0; mdl_addr = i_req_addr; mdl_strb = 8'd0; mdl_data = 128'd0;
            mdl_streak = 0;
            mdl_fields_known = 1'b1;
         end
      end else if (m_res_valid) begin
         mdl_owner = 0;
         mdl_fields_known = 1'b0;
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (ready) begin
         chk("m_req_valid", m_req_valid, mdl_owner != 0);
         chk("grant_d", grant_d, mdl_owner == 1);
         chk("grant_i", grant_i, mdl_owner == 2);
         chk("d_res_valid", d_res_valid, (mdl_owner == 1) && m_res_valid);
         chk("i_res_valid", i_res_valid, (mdl_owner == 2) && m_res_valid);
         chk("i_mrdata", i_mrdata, m_mrdata);
         chk("d_mrdata", d_mrdata, m_mrdata);
         if (mdl_fields_known) begin
            chk("m_req_wen", m_req_wen, mdl_wen);
            chk("m_req_addr", m_req_addr, mdl_addr);
            chk("m_req_strb", m_req_strb, mdl_strb);
            chk("m_req_data", m_req_data, mdl_data);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Bridge: wait for a request, answer after lat cycles, optionally let the
   // owning cache drop its request afterwards.
   task automatic serve(input int lat, input logic [127:0] data, input bit drop, output int who);
      int n;
      int own;
      n = 0;
      while (m_req_valid !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      chk("serve_wait", n < 20, 1'b1);
      who = (grant_d === 1'b1) ? 1 : ((grant_i === 1'b1) ? 2 : 0);
      repeat (lat) step();
      m_res_valid = 1'b1;
      m_mrdata = data;
      own = mdl_owner;
      step();
      m_res_valid = 1'b0;
      if (drop) begin
         if (own == 1) d_req_valid = 1'b0;
         else if (own == 2) i_req_valid = 1'b0;
      end
   endtask

   initial begin
      int who;
      int exp_seq [6] = '{1, 1, 1, 1, 2, 1};
      rst = 1'b1;
      i_req_valid = 1'b0; i_req_addr = 64'd0;
      d_req_valid = 1'b0; d_req_wen = 1'b0; d_req_addr = 64'd0;
      d_req_strb = 8'd0; d_req_data = 128'd0;
      m_res_valid = 1'b0; m_mrdata = 128'd0;
      repeat (2) step();
      rst = 1'b0;
      chk("rst_m_req_valid", m_req_valid, 1'b0);
      chk("rst_grants", {grant_d, grant_i}, 2'b00);
      chk("rst_m_req_addr", m_req_addr, 64'd0);
      step();

      // I-only read: request in cycle 0, bridge answers in cycle 5.
      i_req_valid = 1'b1; i_req_addr = 64'h80000000;
      step();
      chk("ionly_valid", m_req_valid, 1'b1);
      chk("ionly_addr", m_req_addr, 64'h80000000);
      chk("ionly_wen", m_req_wen, 1'b0);
      repeat (4) step();
      m_res_valid = 1'b1; m_mrdata = 128'h00112233445566778899AABBCCDDEEFF;
      #1;
      chk("ionly_res", i_res_valid, 1'b1);
      chk("ionly_mrdata", i_mrdata, 128'h00112233445566778899AABBCCDDEEFF);
      chk("ionly_no_d", d_res_valid, 1'b0);
      step();
      m_res_valid = 1'b0; i_req_valid = 1'b0;
      chk("ionly_done", m_req_valid, 1'b0);
      step();

      // Simultaneous: D write wins, then I read.
      i_req_valid = 1'b1; i_req_addr = 64'h80000040;
      d_req_valid = 1'b1; d_req_wen = 1'b1; d_req_addr = 64'h80001000;
      d_req_strb = 8'hFF; d_req_data = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
      step();
      chk("sim_grant_d", grant_d, 1'b1);
      chk("sim_wen", m_req_wen, 1'b1);
      chk("sim_addr", m_req_addr, 64'h80001000);
      chk("sim_data", m_req_data, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
      serve(2, 128'h1, 1'b1, who);
      chk("sim_idle_gap", m_req_valid, 1'b0);
      step();
      chk("sim_grant_i", grant_i, 1'b1);
      chk("sim_i_addr", m_req_addr, 64'h80000040);
      serve(1, 128'h2, 1'b1, who);

      // Starvation limit: D keeps requesting while I waits.
      i_req_valid = 1'b1; i_req_addr = 64'h80000100;
      d_req_valid = 1'b1; d_req_wen = 1'b0; d_req_addr = 64'h80004000;
      d_req_strb = 8'h00; d_req_data = 128'd0;
      for (int k = 0; k < 6; k++) begin
         serve(1, 128'(k + 16), (k >= 4), who);
         chk($sformatf("starve_grant_%0d", k), who, exp_seq[k]);
      end
      step();

      // D request arriving while I is busy waits its turn.
      i_req_valid = 1'b1; i_req_addr = 64'h80000080;
      step();
      chk("busy_grant_i", grant_i, 1'b1);
      d_req_valid = 1'b1; d_req_wen = 1'b0; d_req_addr = 64'h80002000;
      repeat (3) step();
      chk("busy_hold_addr", m_req_addr, 64'h80000080);
      chk("busy_no_d", grant_d, 1'b0);
      serve(1, 128'h3, 1'b1, who);
      chk("busy_idle_gap", m_req_valid, 1'b0);
      step();
      chk("busy_grant_d", grant_d, 1'b1);
      chk("busy_d_addr", m_req_addr, 64'h80002000);
      serve(2, 128'h4, 1'b1, who);
      step();

      // Reset in the middle of a D transaction.
      d_req_valid = 1'b1; d_req_wen = 1'b1; d_req_addr = 64'h80003000;
      d_req_strb = 8'h0F; d_req_data = 128'h55;
      step();
      chk("rstmid_grant_d", grant_d, 1'b1);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0; d_req_valid = 1'b0;
      chk("rstmid_valid", m_req_valid, 1'b0);
      chk("rstmid_grant", {grant_d, grant_i}, 2'b00);
      chk("rstmid_addr", m_req_addr, 64'd0);
      chk("rstmid_data", m_req_data, 128'd0);
      chk("rstmid_no_res", d_res_valid, 1'b0);
      step();
      d_req_valid = 1'b1; d_req_wen = 1'b0; d_req_addr = 64'h80005000;
      step();
      chk("rstmid_fresh_d", grant_d, 1'b1);
      serve(1, 128'h6, 1'b1, who);
      step();

      // Spurious bridge completion while idle.
      m_res_valid = 1'b1; m_mrdata = 128'h77;
      #1;
      chk("spur_i_res", i_res_valid, 1'b0);
      chk("spur_d_res", d_res_valid, 1'b0);
      step();
      m_res_valid = 1'b0;
      chk("spur_idle", {m_req_valid, grant_d, grant_i}, 3'b000);
      repeat (2) step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
